// File: rtl/pic8259_pkg.sv
// Shared constants and types for the 8259A-compatible PIC request input stage.
// LTIM values mirror the ICW1 LTIM bit encoding.
package pic8259_pkg;

    localparam int IRQ_WIDTH_DEFAULT   = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

    localparam logic LTIM_LEVEL = 1'b1;
    localparam logic LTIM_EDGE  = 1'b0;

    typedef logic [IRQ_WIDTH_DEFAULT-1:0] irq_vector_t;

endpackage

// File: rtl/pic_irq_synchronizer.sv
// Multi-bit N-stage flip-flop synchroniser for the raw asynchronous IR pins.
// All stages reset to 0, so a line reads low for the first cycles after reset.
module pic_irq_synchronizer #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_out = stage[STAGES-1];

endmodule

// File: rtl/pic_interrupt_request_register.sv
// Interrupt Request Register of the 8259A-compatible PIC: synchronises the IR pins,
// applies edge/level triggering and honours clear/freeze from the INTA control logic.
module pic_interrupt_request_register
    import pic8259_pkg::*;
#(
    parameter int IRQ_WIDTH   = IRQ_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [IRQ_WIDTH-1:0] interrupt_request,
    input  logic                 level_or_edge_triggered_config,
    input  logic                 edge_sense_clear,
    input  logic                 freeze,
    input  logic [IRQ_WIDTH-1:0] clear_interrupt_request,
    output logic [IRQ_WIDTH-1:0] interrupt_request_register,
    output logic                 request_pending
);

    logic [IRQ_WIDTH-1:0] sync_irq;
    logic [IRQ_WIDTH-1:0] irr;
    logic [IRQ_WIDTH-1:0] irr_next;
    logic [IRQ_WIDTH-1:0] armed;
    logic [IRQ_WIDTH-1:0] armed_next;

    pic_irq_synchronizer #(
        .WIDTH  (IRQ_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (interrupt_request),
        .sync_out (sync_irq)
    );

    // An armed line has been seen low since its last request was taken, so the next
    // high level counts as a fresh rising edge. Clears always beat a new request.
    always_comb begin
        irr_next   = irr;
        armed_next = armed;
        for (int i = 0; i < IRQ_WIDTH; i++) begin
            if (edge_sense_clear || clear_interrupt_request[i]) begin
                irr_next[i] = 1'b0;
            end else if (freeze) begin
                irr_next[i] = irr[i];
            end else if (level_or_edge_triggered_config == LTIM_LEVEL) begin
                irr_next[i] = sync_irq[i];
            end else if (sync_irq[i]) begin
                irr_next[i] = irr[i] | armed[i];
            end else begin
                irr_next[i] = 1'b0;
            end

            if (edge_sense_clear || clear_interrupt_request[i] || (irr_next[i] && !irr[i])) begin
                armed_next[i] = 1'b0;
            end else if (!sync_irq[i]) begin
                armed_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr             <= '0;
            armed           <= '0;
            request_pending <= 1'b0;
        end else begin
            irr             <= irr_next;
            armed           <= armed_next;
            request_pending <= |irr_next;
        end
    end

    assign interrupt_request_register = irr;

endmodule
